matmul_seq_ctrl: RTL and testbench

- Sequencer for the two-stage 8x8 matrix-multiply datapath: stage-1 multiplier, then 8-entry temp BRAM, then stage-2 multiplier.
- On a start pulse it runs stage 1 row by row and writes each 64-bit row result into the temp BRAM. It then streams the BRAM back into stage 2 and pulses done.
- It replaces the free-running enable, clear, valid and temp-address inputs that the host drives today at the datapath top.

---
 rtl/matmul_seq_ctrl_pkg.sv | 25 ++
 rtl/matmul_seq_ctrl_if.sv | 38 +++
 rtl/matmul_seq_ctrl_timer.sv | 25 ++
 rtl/matmul_seq_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_seq_ctrl_pkg.sv
// Shared types and defaults for the two-stage matrix-multiply sequencer.
package matmul_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_S1_FEED,
      ST_S1_WAIT,
      ST_S1_WRITE,
      ST_S2_FEED,
      ST_S2_WAIT,
      ST_DONE
   } state_e;

   localparam logic [1:0] MODE_FULL = 2'b00;
   localparam logic [1:0] MODE_S1   = 2'b01;
   localparam logic [1:0] MODE_S2   = 2'b10;
   localparam logic [1:0] MODE_RSVD = 2'b11;

   localparam int ROWS_DEF    = 8;
   localparam int K_LEN_DEF   = 8;
   localparam int ADDR_W_DEF  = 3;
   localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Host/datapath-facing signal bundle of the sequencer; slave is the sequencer side.
interface matmul_seq_ctrl_if #(
   parameter int ADDR_W = 3
);
   logic              start_i;
   logic              abort_i;
   logic [1:0]        mode_i;
   logic              mm1_done_i;
   logic              mm2_done_i;
   logic              en_o;
   logic              clear_o;
   logic              valid1_o;
   logic [ADDR_W-1:0] row_o;
   logic [ADDR_W-1:0] beat_o;
   logic              wr_temp_en_o;
   logic [ADDR_W-1:0] wr_temp_addr_o;
   logic              rd_temp_en_o;
   logic [ADDR_W-1:0] rd_temp_addr_o;
   logic              valid2_o;
   logic [1:0]        mode_o;
   logic              busy_o;
   logic              done_o;
   logic              err_o;

   modport slave (
      input  start_i, abort_i, mode_i, mm1_done_i, mm2_done_i,
      output en_o, clear_o, valid1_o, row_o, beat_o,
             wr_temp_en_o, wr_temp_addr_o, rd_temp_en_o, rd_temp_addr_o,
             valid2_o, mode_o, busy_o, done_o, err_o
   );

   modport master (
      output start_i, abort_i, mode_i, mm1_done_i, mm2_done_i,
      input  en_o, clear_o, valid1_o, row_o, beat_o,
             wr_temp_en_o, wr_temp_addr_o, rd_temp_en_o, rd_temp_addr_o,
             valid2_o, mode_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/matmul_seq_ctrl_timer.sv
// Loadable wait-cycle counter; expired_o is high during the last allowed wait cycle.
module seq_wait_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int W = $clog2(TIMEOUT) + 1;

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || load_i) begin
         cnt_q <= '0;
      end else if (en_i && !expired_o) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign expired_o = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the stage-1 / temp BRAM / stage-2 matrix-multiply datapath.
module matmul_seq_ctrl
   import matmul_pkg::*;
#(
   parameter int ROWS    = ROWS_DEF,
   parameter int K_LEN   = K_LEN_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   matmul_seq_ctrl_if.slave bus
);
   localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(K_LEN - 1);
   localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(ROWS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] row_q, row_d;
   logic [ADDR_W-1:0] beat_q, beat_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [1:0]        mode_q, mode_d;
   logic              err_q, err_d;
   logic              en_q, en_d;
   logic              clear_q, clear_d;
   logic              valid1_q, valid1_d;
   logic              wr_en_q, wr_en_d;
   logic              rd_en_q, rd_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              valid2_q;
   logic              abort_clr;
   logic              tmr_load, tmr_en, tmr_expired;

   seq_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (tmr_load),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   // Next-state and counter logic.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      beat_d    = beat_q;
      mode_d    = mode_q;
      err_d     = err_q;
      abort_clr = 1'b0;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;

      if (state_q != ST_IDLE && bus.abort_i) begin
         state_d   = ST_IDLE;
         row_d     = '0;
         beat_d    = '0;
         abort_clr = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start_i) begin
                  if (bus.mode_i == MODE_RSVD) begin
                     err_d = 1'b1;
                  end else begin
                     mode_d  = bus.mode_i;
                     err_d   = 1'b0;
                     row_d   = '0;
                     beat_d  = '0;
                     state_d = ST_CLEAR;
                  end
               end
            end
            ST_CLEAR: begin
               row_d   = '0;
               beat_d  = '0;
               state_d = (mode_q == MODE_S2) ? ST_S2_FEED : ST_S1_FEED;
            end
            ST_S1_FEED: begin
               if (beat_q == K_LAST) begin
                  beat_d   = '0;
                  tmr_load = 1'b1;
                  state_d  = ST_S1_WAIT;
               end else begin
                  beat_d = beat_q + ADDR_W'(1);
               end
            end
            ST_S1_WAIT: begin
               tmr_en = 1'b1;
               // A done arriving on the expiring cycle still counts as success.
               if (bus.mm1_done_i) begin
                  state_d = ST_S1_WRITE;
               end else if (tmr_expired) begin
                  err_d   = 1'b1;
                  row_d   = '0;
                  state_d = ST_IDLE;
               end
            end
            ST_S1_WRITE: begin
               beat_d = '0;
               if (row_q == R_LAST) begin
                  row_d   = '0;
                  state_d = (mode_q == MODE_S1) ? ST_DONE : ST_S2_FEED;
               end else begin
                  row_d   = row_q + ADDR_W'(1);
                  state_d = ST_S1_FEED;
               end
            end
            ST_S2_FEED: begin
               if (beat_q == R_LAST) begin
                  beat_d   = '0;
                  tmr_load = 1'b1;
                  state_d  = ST_S2_WAIT;
               end else begin
                  beat_d = beat_q + ADDR_W'(1);
               end
            end
            ST_S2_WAIT: begin
               tmr_en = 1'b1;
               if (bus.mm2_done_i) begin
                  state_d = ST_DONE;
               end else if (tmr_expired) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from the state being entered so they can be registered.
   always_comb begin
      en_d      = 1'b0;
      clear_d   = abort_clr;
      valid1_d  = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      rd_en_d   = 1'b0;
      rd_addr_d = '0;
      done_d    = 1'b0;
      busy_d    = (state_d != ST_IDLE);
      case (state_d)
         ST_CLEAR: begin
            en_d    = 1'b1;
            clear_d = 1'b1;
         end
         ST_S1_FEED: begin
            en_d     = 1'b1;
            valid1_d = 1'b1;
         end
         ST_S1_WAIT, ST_S2_WAIT: begin
            en_d = 1'b1;
         end
         ST_S1_WRITE: begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_d;
            clear_d   = 1'b1;
         end
         ST_S2_FEED: begin
            en_d      = 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = beat_d;
         end
         ST_DONE: begin
            done_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         row_q     <= '0;
         beat_q    <= '0;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         mode_q    <= '0;
         err_q     <= 1'b0;
         en_q      <= 1'b0;
         clear_q   <= 1'b0;
         valid1_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid2_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         beat_q    <= beat_d;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         mode_q    <= mode_d;
         err_q     <= err_d;
         en_q      <= en_d;
         clear_q   <= clear_d;
         valid1_q  <= valid1_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         valid2_q  <= rd_en_q;
      end
   end

   assign bus.en_o           = en_q;
   assign bus.clear_o        = clear_q;
   assign bus.valid1_o       = valid1_q;
   assign bus.row_o          = row_q;
   assign bus.beat_o         = beat_q;
   assign bus.wr_temp_en_o   = wr_en_q;
   assign bus.wr_temp_addr_o = wr_addr_q;
   assign bus.rd_temp_en_o   = rd_en_q;
   assign bus.rd_temp_addr_o = rd_addr_q;
   assign bus.valid2_o       = valid2_q;
   assign bus.mode_o         = mode_q;
   assign bus.busy_o         = busy_q;
   assign bus.done_o         = done_q;
   assign bus.err_o          = err_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl: per-mode vector table plus corner-case sequences.
module tb_matmul_seq_ctrl;
   import matmul_pkg::*;

   typedef struct {
      logic [1:0] mode;
      bit         mid_start;
      int         lat;
      int         nwr;
      int         nrd;
      int         nv1;
      bit         err;
      bit         done;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   matmul_seq_ctrl_if #(.ADDR_W(3)) bus ();

   matmul_seq_ctrl #(
      .ROWS    (8),
      .K_LEN   (8),
      .ADDR_W  (3),
      .TIMEOUT (64)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int wr_q[$];
   int rd_q[$];
   int n_wr = 0, n_rd = 0, n_v1 = 0, n_done = 0;
   bit prev_rd = 1'b0;
   bit v2_chk_en = 1'b1;
   bit model_en1 = 1'b1;
   bit arm1 = 1'b0, arm2 = 1'b0;
   int since1 = 0, since2 = 0;
   vec_t vecs[5];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endfunction

   // Datapath model: stage-1 done in the 3rd cycle after valid1 drops, stage-2 done 2 cycles after last valid2.
   always @(negedge clk) begin
      bus.mm1_done_i = 1'b0;
      bus.mm2_done_i = 1'b0;
      if (bus.valid1_o) begin
         arm1   = 1'b1;
         since1 = 0;
      end else if (arm1) begin
         since1++;
         if (since1 == 3) begin
            arm1 = 1'b0;
            if (model_en1) bus.mm1_done_i = 1'b1;
         end
      end
      if (bus.valid2_o) begin
         arm2   = 1'b1;
         since2 = 0;
      end else if (arm2) begin
         since2++;
         if (since2 == 2) begin
            arm2 = 1'b0;
            bus.mm2_done_i = 1'b1;
         end
      end
   end

   // Scoreboard monitor: temp BRAM writes/reads pop expected addresses.
   always @(negedge clk) begin
      int exp_a;
      if (bus.wr_temp_en_o) begin
         n_wr++;
         if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
         else begin
            exp_a = wr_q.pop_front();
            check("wr_addr", int'(bus.wr_temp_addr_o), exp_a);
         end
      end
      if (bus.rd_temp_en_o) begin
         n_rd++;
         if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
         else begin
            exp_a = rd_q.pop_front();
            check("rd_addr", int'(bus.rd_temp_addr_o), exp_a);
         end
      end
      if (v2_chk_en && (bus.valid2_o || prev_rd)) check("valid2_lag", int'(bus.valid2_o), int'(prev_rd));
      prev_rd = bus.rd_temp_en_o;
      if (bus.valid1_o) n_v1++;
      if (bus.done_o) n_done++;
   end

   function automatic int all_outputs();
      logic [22:0] v;
      v = {bus.en_o, bus.clear_o, bus.valid1_o, bus.row_o, bus.beat_o,
           bus.wr_temp_en_o, bus.wr_temp_addr_o, bus.rd_temp_en_o, bus.rd_temp_addr_o,
           bus.valid2_o, bus.mode_o, bus.busy_o, bus.done_o, bus.err_o};
      return int'(v);
   endfunction

   task automatic begin_op(input logic [1:0] mode, input int nwr, input int nrd);
      n_wr = 0; n_rd = 0; n_v1 = 0; n_done = 0;
      for (int r = 0; r < nwr; r++) wr_q.push_back(r);
      for (int r = 0; r < nrd; r++) rd_q.push_back(r);
      bus.mode_i  = mode;
      bus.start_i = 1'b1;
      start_cyc   = cyc + 1;
      @(negedge clk);
      bus.start_i = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      bit seen;
      int lat;
      begin_op(v.mode, v.nwr, v.nrd);
      check($sformatf("v%0d_busy_after_start", idx), int'(bus.busy_o), (v.mode == MODE_RSVD) ? 0 : 1);
      check($sformatf("v%0d_err_after_start", idx), int'(bus.err_o), int'(v.err));
      seen = 1'b0;
      lat  = 0;
      if (v.done) begin
         for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.done_o) begin
               seen = 1'b1;
               lat  = cyc - start_cyc;
            end
            if (v.mid_start && i == 30) begin
               bus.start_i = 1'b1;
               bus.mode_i  = MODE_S1;
            end
            if (v.mid_start && i == 31) begin
               bus.start_i = 1'b0;
               bus.mode_i  = v.mode;
            end
         end
         check($sformatf("v%0d_done_seen", idx), int'(seen), 1);
         check($sformatf("v%0d_done_latency", idx), lat, v.lat);
         check($sformatf("v%0d_mode_o", idx), int'(bus.mode_o), int'(v.mode));
         @(negedge clk);
         check($sformatf("v%0d_busy_after_done", idx), int'(bus.busy_o), 0);
      end else begin
         repeat (20) @(negedge clk);
         check($sformatf("v%0d_busy_idle", idx), int'(bus.busy_o), 0);
      end
      repeat (5) @(negedge clk);
      check($sformatf("v%0d_done_count", idx), n_done, int'(v.done));
      check($sformatf("v%0d_writes", idx), n_wr, v.nwr);
      check($sformatf("v%0d_reads", idx), n_rd, v.nrd);
      check($sformatf("v%0d_valid1_beats", idx), n_v1, v.nv1);
      check($sformatf("v%0d_err_end", idx), int'(bus.err_o), int'(v.err));
      check($sformatf("v%0d_queues_empty", idx), wr_q.size() + rd_q.size(), 0);
      $display("vector %0d mode=%0b latency=%0d writes=%0d reads=%0d done=%0d", idx, v.mode, lat, n_wr, n_rd, n_done);
   endtask

   initial begin
      bit seen;
      int lat;

      vecs[0] = '{2'b00, 1'b0, 108, 8, 8, 64, 1'b0, 1'b1};
      vecs[1] = '{2'b01, 1'b0,  97, 8, 0, 64, 1'b0, 1'b1};
      vecs[2] = '{2'b10, 1'b0,  12, 0, 8,  0, 1'b0, 1'b1};
      vecs[3] = '{2'b11, 1'b0,   0, 0, 0,  0, 1'b1, 1'b0};
      vecs[4] = '{2'b00, 1'b1, 108, 8, 8, 64, 1'b0, 1'b1};

      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      bus.mode_i  = 2'b00;
      repeat (3) @(negedge clk);
      check("reset_outputs", all_outputs(), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_outputs", all_outputs(), 0);

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // Stage-1 done never arrives: timeout after 64 wait cycles.
      model_en1 = 1'b0;
      begin_op(MODE_FULL, 0, 0);
      seen = 1'b0;
      lat  = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (!bus.busy_o) begin
            seen = 1'b1;
            lat  = cyc - start_cyc;
         end
      end
      check("timeout_seen", int'(seen), 1);
      check("timeout_latency", lat, 73);
      check("timeout_err", int'(bus.err_o), 1);
      repeat (5) @(negedge clk);
      check("timeout_no_done", n_done, 0);
      check("timeout_no_write", n_wr, 0);
      model_en1 = 1'b1;
      $display("timeout run latency=%0d err=%0d", lat, bus.err_o);

      // Abort on beat 4 of row 3.
      begin_op(MODE_FULL, 3, 0);
      check("abort_err_cleared", int'(bus.err_o), 0);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (bus.valid1_o && bus.row_o == 3'd3 && bus.beat_o == 3'd4) seen = 1'b1;
      end
      check("abort_point_seen", int'(seen), 1);
      bus.abort_i = 1'b1;
      @(negedge clk);
      bus.abort_i = 1'b0;
      check("abort_busy", int'(bus.busy_o), 0);
      check("abort_clear", int'(bus.clear_o), 1);
      check("abort_en", int'(bus.en_o), 0);
      @(negedge clk);
      check("abort_clear_one_cycle", int'(bus.clear_o), 0);
      repeat (30) @(negedge clk);
      check("abort_no_done", n_done, 0);
      check("abort_writes", n_wr, 3);
      check("abort_err_unchanged", int'(bus.err_o), 0);
      $display("abort run writes=%0d done=%0d", n_wr, n_done);

      // Reset during stage-2 feed.
      begin_op(MODE_FULL, 8, 8);
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (bus.rd_temp_en_o && bus.rd_temp_addr_o == 3'd3) seen = 1'b1;
      end
      check("reset_point_seen", int'(seen), 1);
      v2_chk_en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("midrun_reset_outputs", all_outputs(), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("midrun_reset_no_done", n_done, 0);
      check("midrun_reset_idle", int'(bus.busy_o), 0);
      rd_q.delete();
      check("midrun_reset_writes_done", wr_q.size(), 0);
      v2_chk_en = 1'b1;
      $display("reset run reads=%0d done=%0d", n_rd, n_done);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
